// File: rtl/addr_seq_reg.sv
// rtl/addr_seq_reg.sv - paged address register with load, inc/dec and indexed add with page fix-up
module addr_seq_reg #(
  parameter int                ADDR_W  = 16,
  parameter int                LO_W    = 8,
  parameter logic [ADDR_W-1:0] RST_VAL = '0,
  parameter bit                FIX_EN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [LO_W-1:0]        lo_in,
  input  logic [ADDR_W-LO_W-1:0] hi_in,
  input  logic                   ld_lo_w_clr,
  input  logic [LO_W-1:0]        offset,
  input  logic                   offset_signed,
  output logic [ADDR_W-1:0]      addr_out,
  output logic                   page_cross,
  output logic                   done
);

  localparam int HI_W = ADDR_W - LO_W;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_LD_LO   = 3'd1,
    OP_LD_HI   = 3'd2,
    OP_LD_BOTH = 3'd3,
    OP_INC     = 3'd4,
    OP_DEC     = 3'd5,
    OP_ADD_IDX = 3'd6,
    OP_CLR_HI  = 3'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    FIX  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [LO_W-1:0] lo_q, lo_d;
  logic [HI_W-1:0] hi_q, hi_d;
  logic            page_cross_q, page_cross_d;
  logic            done_q, done_d;
  logic            adj_dn_q, adj_dn_d;

  logic              accept;
  op_e               op;
  logic [ADDR_W-1:0] full_inc;
  logic [ADDR_W-1:0] full_dec;
  logic [LO_W+1:0]   off_ext;
  logic [LO_W+1:0]   idx_sum;
  logic              idx_neg;
  logic              idx_ovf;
  logic              idx_cross;

  assign cmd_ready  = (state_q == IDLE) && rst_n;
  assign accept     = cmd_valid && cmd_ready;
  assign op         = op_e'(cmd_op);
  assign addr_out   = {hi_q, lo_q};
  assign page_cross = page_cross_q;
  assign done       = done_q;

  assign full_inc = {hi_q, lo_q} + ADDR_W'(1);
  assign full_dec = {hi_q, lo_q} - ADDR_W'(1);

  // Two guard bits: bit LO_W+1 flags a negative sum, bit LO_W an overflow past the page.
  assign off_ext   = offset_signed ? {{2{offset[LO_W-1]}}, offset} : {2'b00, offset};
  assign idx_sum   = {2'b00, lo_q} + off_ext;
  assign idx_neg   = idx_sum[LO_W+1];
  assign idx_ovf   = !idx_sum[LO_W+1] && idx_sum[LO_W];
  assign idx_cross = idx_neg || idx_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lo_q         <= RST_VAL[LO_W-1:0];
      hi_q         <= RST_VAL[ADDR_W-1:LO_W];
      page_cross_q <= 1'b0;
      done_q       <= 1'b0;
      adj_dn_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      page_cross_q <= page_cross_d;
      done_q       <= done_d;
      adj_dn_q     <= adj_dn_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    page_cross_d = page_cross_q;
    done_d       = 1'b0;
    adj_dn_d     = adj_dn_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          done_d       = 1'b1;
          page_cross_d = 1'b0;
          case (op)
            OP_NOP: ;
            OP_LD_LO:   lo_d = lo_in;
            OP_LD_HI:   hi_d = hi_in;
            OP_LD_BOTH: begin
              lo_d = lo_in;
              hi_d = hi_in;
            end
            OP_INC: begin
              lo_d = full_inc[LO_W-1:0];
              hi_d = full_inc[ADDR_W-1:LO_W];
            end
            OP_DEC: begin
              lo_d = full_dec[LO_W-1:0];
              hi_d = full_dec[ADDR_W-1:LO_W];
            end
            OP_ADD_IDX: begin
              lo_d = idx_sum[LO_W-1:0];
              if (idx_cross) begin
                page_cross_d = 1'b1;
                // With fix-up disabled the high field is left for software to correct.
                if (FIX_EN) begin
                  state_d  = FIX;
                  done_d   = 1'b0;
                  adj_dn_d = idx_neg;
                end
              end
            end
            OP_CLR_HI: begin
              hi_d = '0;
              if (ld_lo_w_clr) lo_d = lo_in;
            end
            default: ;
          endcase
        end
      end
      FIX: begin
        hi_d    = adj_dn_q ? (hi_q - HI_W'(1)) : (hi_q + HI_W'(1));
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_addr_seq_reg.sv
// tb/tb_addr_seq_reg.sv - directed bench for addr_seq_reg with fix-up enabled and disabled
module tb_addr_seq_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [7:0]  lo_in;
  logic [7:0]  hi_in;
  logic        ld_lo_w_clr;
  logic [7:0]  offset;
  logic        offset_signed;

  logic        ready0, pc0, done0;
  logic [15:0] addr0;
  logic        ready1, pc1, done1;
  logic [15:0] addr1;

  int tests  = 0;
  int failed = 0;

  localparam logic [2:0] NOP = 3'd0, LD_LO = 3'd1, LD_HI = 3'd2, LD_BOTH = 3'd3,
                         INC = 3'd4, DEC = 3'd5, ADD_IDX = 3'd6, CLR_HI = 3'd7;

  always #5 clk = ~clk;

  addr_seq_reg #(.ADDR_W(16), .LO_W(8), .RST_VAL(16'hFFFC), .FIX_EN(1'b1)) u_fix (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready0), .cmd_op(cmd_op),
    .lo_in(lo_in), .hi_in(hi_in), .ld_lo_w_clr(ld_lo_w_clr), .offset(offset),
    .offset_signed(offset_signed), .addr_out(addr0), .page_cross(pc0), .done(done0)
  );

  addr_seq_reg #(.ADDR_W(16), .LO_W(8), .RST_VAL(16'h0000), .FIX_EN(1'b0)) u_nofix (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready1), .cmd_op(cmd_op),
    .lo_in(lo_in), .hi_in(hi_in), .ld_lo_w_clr(ld_lo_w_clr), .offset(offset),
    .offset_signed(offset_signed), .addr_out(addr1), .page_cross(pc1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] lo, input logic [7:0] hi,
                      input logic clr, input logic [7:0] off, input logic sgn);
    cmd_valid = 1'b1; cmd_op = op; lo_in = lo; hi_in = hi;
    ld_lo_w_clr = clr; offset = off; offset_signed = sgn;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; lo_in = '0; hi_in = '0;
    ld_lo_w_clr = 1'b0; offset = '0; offset_signed = 1'b0;
    step(); step();
    chk("rst_ready_low", ready0, 0);
    chk("rst_addr_held", addr0, 16'hFFFC);
    rst_n = 1'b1;
    #1;
    chk("rst_addr", addr0, 16'hFFFC);
    chk("rst_ready", ready0, 1);
    chk("rst_done", done0, 0);
    chk("rst_pc", pc0, 0);
    chk("rst_addr_nofix", addr1, 16'h0000);
    step();
    chk("idle_done", done0, 0);

    send(LD_BOTH, 8'hFF, 8'h12, 0, 0, 0);
    chk("ldboth_addr", addr0, 16'h12FF);
    chk("ldboth_done", done0, 1);
    send(INC, 0, 0, 0, 0, 0);
    chk("inc_carry", addr0, 16'h1300);
    chk("inc_done_b2b", done0, 1);
    step();
    chk("done_one_cycle", done0, 0);
    send(LD_LO, 8'h34, 0, 0, 0, 0);
    chk("ld_lo", addr0, 16'h1334);
    send(LD_HI, 0, 8'hAB, 0, 0, 0);
    chk("ld_hi", addr0, 16'hAB34);
    send(CLR_HI, 8'h77, 0, 0, 0, 0);
    chk("clr_hi_keep_lo", addr0, 16'h0034);
    send(CLR_HI, 8'h77, 8'h55, 1, 0, 0);
    chk("clr_hi_load_lo", addr0, 16'h0077);
    send(LD_BOTH, 8'h00, 8'h00, 0, 0, 0);
    send(DEC, 0, 0, 0, 0, 0);
    chk("dec_wrap", addr0, 16'hFFFF);
    send(INC, 0, 0, 0, 0, 0);
    chk("inc_wrap", addr0, 16'h0000);

    send(LD_BOTH, 8'hF0, 8'h20, 0, 0, 0);
    send(ADD_IDX, 0, 0, 0, 8'h20, 0);
    chk("add_up_lo", addr0, 16'h2010);
    chk("add_up_pc", pc0, 1);
    chk("add_up_busy", ready0, 0);
    chk("add_up_nodone", done0, 0);
    step();
    chk("add_up_fixed", addr0, 16'h2110);
    chk("add_up_done", done0, 1);
    chk("add_up_ready", ready0, 1);
    chk("add_up_pc_hold", pc0, 1);
    send(LD_BOTH, 8'hF0, 8'h20, 0, 0, 0);
    chk("ld_clears_pc", pc0, 0);
    send(ADD_IDX, 0, 0, 0, 8'h05, 0);
    chk("add_nocross", addr0, 16'h20F5);
    chk("add_nocross_pc", pc0, 0);
    chk("add_nocross_done", done0, 1);
    chk("add_nocross_ready", ready0, 1);

    send(LD_BOTH, 8'h05, 8'h21, 0, 0, 0);
    send(ADD_IDX, 0, 0, 0, 8'hF0, 1);
    chk("add_dn_lo", addr0, 16'h21F5);
    chk("add_dn_pc", pc0, 1);
    chk("nofix_addr", addr1, 16'h21F5);
    chk("nofix_pc", pc1, 1);
    chk("nofix_done", done1, 1);
    chk("nofix_ready", ready1, 1);
    step();
    chk("add_dn_fixed", addr0, 16'h20F5);
    chk("add_dn_done", done0, 1);
    send(NOP, 0, 0, 0, 0, 0);
    chk("nop_addr", addr0, 16'h20F5);
    chk("nop_clears_pc", pc0, 0);
    chk("nop_done", done0, 1);

    send(LD_BOTH, 8'hF0, 8'hFF, 0, 0, 0);
    send(ADD_IDX, 0, 0, 0, 8'h20, 0);
    step();
    chk("fix_hi_wrap_up", addr0, 16'h0010);
    send(LD_BOTH, 8'h05, 8'h00, 0, 0, 0);
    send(ADD_IDX, 0, 0, 0, 8'hF0, 1);
    step();
    chk("fix_hi_wrap_dn", addr0, 16'hFFF5);
    send(LD_BOTH, 8'h80, 8'h30, 0, 0, 0);
    send(ADD_IDX, 0, 0, 0, 8'h90, 0);
    chk("unsigned_big_off", addr0, 16'h3010);
    step();
    chk("unsigned_big_fixed", addr0, 16'h3110);

    send(LD_BOTH, 8'hF0, 8'h20, 0, 0, 0);
    send(ADD_IDX, 0, 0, 0, 8'h20, 0);
    chk("pre_rst_in_fix", ready0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_fix_addr", addr0, 16'hFFFC);
    chk("rst_fix_done", done0, 0);
    chk("rst_fix_pc", pc0, 0);
    step();
    chk("rst_fix_done_edge", done0, 0);
    rst_n = 1'b1;
    step();
    chk("rst_fix_idle", ready0, 1);
    chk("rst_fix_no_done", done0, 0);
    chk("rst_fix_addr_after", addr0, 16'hFFFC);

    send(LD_BOTH, 8'hF0, 8'h20, 0, 0, 0);
    send(ADD_IDX, 0, 0, 0, 8'h20, 0);
    cmd_valid = 1'b1; cmd_op = LD_LO; lo_in = 8'hAA;
    step();
    chk("held_not_taken", addr0, 16'h2110);
    chk("held_fix_done", done0, 1);
    chk("held_ready", ready0, 1);
    step();
    cmd_valid = 1'b0;
    chk("held_applied", addr0, 16'h21AA);
    chk("held_done", done0, 1);
    step();
    chk("held_once_done", done0, 0);
    chk("held_once_addr", addr0, 16'h21AA);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
